// File: rtl/remote_comm.sv
// Host-side UART command sender / response receiver for the knight robot (8N1, LSB first).
// Optional framing-error reporting via the REMOTE_COMM_FRM_ERR_EN macro (adds frm_err).
module remote_comm #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy,
`ifdef REMOTE_COMM_FRM_ERR_EN
    output logic        frm_err,
`endif
    input  logic        clr_rx_rdy
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] BaudMax = CntW'(BAUD_DIV - 1);
    localparam logic [CntW-1:0] HalfDiv = CntW'(BAUD_DIV / 2);

    // ---------------------------------------------------------------- sender
    typedef enum logic [1:0] {TxIdle, TxHi, TxLo} tx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [7:0]      cmd_lo_q, cmd_lo_d;
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic [CntW-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic            tx_q, tx_d;
    logic            cmd_sent_q, cmd_sent_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            cmd_lo_q   <= '0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            cmd_sent_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            cmd_lo_q   <= cmd_lo_d;
            tx_shift_q <= tx_shift_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        cmd_lo_d   = cmd_lo_q;
        tx_shift_d = tx_shift_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        cmd_sent_d = cmd_sent_q;
        case (tx_state_q)
            TxIdle: begin
                tx_d = 1'b1;
                if (send_cmd) begin
                    // High byte goes straight into the shifter; only the low byte waits.
                    cmd_lo_d   = cmd[7:0];
                    cmd_sent_d = 1'b0;
                    tx_shift_d = {1'b1, cmd[15:8], 1'b0};
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_d       = 1'b0;
                    tx_state_d = TxHi;
                end
            end
            TxHi, TxLo: begin
                if (tx_baud_q == BaudMax) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_state_q == TxHi) begin
                            tx_shift_d = {1'b1, cmd_lo_q, 1'b0};
                            tx_bit_d   = '0;
                            tx_d       = 1'b0;
                            tx_state_d = TxLo;
                        end else begin
                            cmd_sent_d = 1'b1;
                            tx_d       = 1'b1;
                            tx_state_d = TxIdle;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign TX       = tx_q;
    assign cmd_sent = cmd_sent_q;

    // -------------------------------------------------------------- receiver
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e       rx_state_q, rx_state_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      resp_q, resp_d;
    logic            resp_rdy_q, resp_rdy_d;
    logic            rx_done;
    logic            byte_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = HalfDiv;
                end
            end
            RxStart: begin
                if (rx_cnt_q == '0) begin
                    // Line high again at mid start bit: a glitch, not a frame.
                    if (rx_sync_q) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxData;
                        rx_cnt_d   = BaudMax;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BaudMax;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == '0) begin
                    rx_done    = 1'b1;
                    rx_state_d = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

`ifdef REMOTE_COMM_FRM_ERR_EN
    logic frm_err_q, frm_err_d;

    // rx_sync_q holds the stop-bit sample in the rx_done cycle.
    assign byte_ok = rx_done && rx_sync_q;

    always_comb begin
        frm_err_d = frm_err_q;
        if (clr_rx_rdy) frm_err_d = 1'b0;
        if (rx_done)    frm_err_d = !rx_sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frm_err_q <= 1'b0;
        else     frm_err_q <= frm_err_d;
    end

    assign frm_err = frm_err_q;
`else
    assign byte_ok = rx_done;
`endif

    always_comb begin
        resp_d     = byte_ok ? rx_shift_q : resp_q;
        resp_rdy_d = byte_ok | (resp_rdy_q & ~clr_rx_rdy);
    end

    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Randomised self-checking bench for remote_comm: a behavioural UART decodes TX and drives RX.
module tb_remote_comm;

    localparam int unsigned B = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd = '0;
    logic        send_cmd = 1'b0;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_rx_rdy = 1'b0;
`ifdef REMOTE_COMM_FRM_ERR_EN
    logic        frm_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] mon_q[$];
    logic       mon_ok_q[$];
    logic [7:0] exp_resp = 8'h00;
    logic       exp_rdy  = 1'b0;
    logic       exp_frm  = 1'b0;

    always #5 clk = ~clk;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .send_cmd   (send_cmd),
        .cmd_sent   (cmd_sent),
        .resp       (resp),
        .resp_rdy   (resp_rdy),
`ifdef REMOTE_COMM_FRM_ERR_EN
        .frm_err    (frm_err),
`endif
        .clr_rx_rdy (clr_rx_rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference UART receiver watching TX, sampled mid-bit on falling clock edges.
    initial begin : tx_monitor
        logic [7:0] mb;
        logic       mok;
        wait (rst == 1'b0);
        forever begin
            @(negedge TX);
            repeat (B / 2) @(negedge clk);
            mok = (TX == 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(negedge clk);
                mb[i] = TX;
            end
            repeat (B) @(negedge clk);
            mok = mok && (TX == 1'b1);
            mon_q.push_back(mb);
            mon_ok_q.push_back(mok);
        end
    end

    task automatic check_tx();
        while (exp_tx_q.size() > 0) begin
            logic [7:0] e;
            e = exp_tx_q.pop_front();
            if (mon_q.size() == 0) begin
                check("tx_byte_missing", 32'd0, 32'd1);
            end else begin
                check("tx_byte", mon_q.pop_front(), e);
                check("tx_framing", mon_ok_q.pop_front(), 1'b1);
            end
        end
        check("tx_extra_bytes", mon_q.size(), 0);
    endtask

    task automatic check_rx();
        check("resp", resp, exp_resp);
        check("resp_rdy", resp_rdy, exp_rdy);
`ifdef REMOTE_COMM_FRM_ERR_EN
        check("frm_err", frm_err, exp_frm);
`endif
    endtask

    task automatic pulse_clr();
        clr_rx_rdy = 1'b1;
        @(negedge clk);
        clr_rx_rdy = 1'b0;
        exp_rdy = 1'b0;
        exp_frm = 1'b0;
    endtask

    // Send a command; optionally fire an ignored pulse `dly` cycles into the transfer.
    task automatic do_cmd(input logic [15:0] c, input logic extra, input logic [15:0] c2,
                          input int dly);
        int cnt;
        cmd = c;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        exp_tx_q.push_back(c[15:8]);
        exp_tx_q.push_back(c[7:0]);
        cnt = 1;
        check("tx_start_bit", TX, 1'b0);
        check("cmd_sent_cleared", cmd_sent, 1'b0);
        if (extra) begin
            repeat (dly) @(negedge clk);
            cmd = c2;
            send_cmd = 1'b1;
            @(negedge clk);
            send_cmd = 1'b0;
            cnt += dly + 1;
            check("cmd_sent_busy_pulse", cmd_sent, 1'b0);
        end
        while (!cmd_sent && cnt < 20 * B + 40) begin
            @(negedge clk);
            cnt++;
        end
        check("cmd_latency", cnt, 20 * B + 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int gap);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop_bit;
        repeat (B) @(negedge clk);
        RX = 1'b1;
`ifdef REMOTE_COMM_FRM_ERR_EN
        if (!stop_bit) begin
            exp_frm = 1'b1;
        end else begin
            exp_resp = b;
            exp_rdy  = 1'b1;
            exp_frm  = 1'b0;
        end
`else
        exp_resp = b;
        exp_rdy  = 1'b1;
`endif
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1'b1);
        check("rst_cmd_sent", cmd_sent, 1'b0);
        check_rx();
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Command 16'h2000 with exact latency
        do_cmd(16'h2000, 1'b0, 16'h0, 0);
        check_tx();
        repeat (5) @(negedge clk);
        check("cmd_sent_sticky", cmd_sent, 1'b1);

        // Robot reply A5, then clear
        send_rx(8'hA5, 1'b1, 2);
        check_rx();
        pulse_clr();
        check_rx();

        // Ignored pulse while busy
        do_cmd(16'h1234, 1'b1, 16'h5A3C, 100);
        repeat (2 * B) @(negedge clk);
        check_tx();

        // Short glitch must not produce a byte
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (3 * B) @(negedge clk);
        check_rx();

        // Back-to-back bytes; clear coincident with the second completion
        fork
            begin
                send_rx(8'h0F, 1'b1, 0);
                send_rx(8'hF0, 1'b1, 2);
            end
            begin
                int k;
                k = 0;
                while (resp !== 8'h0F && k < 20 * B) begin
                    @(negedge clk);
                    k++;
                end
                check("b2b_first_resp", resp, 8'h0F);
                clr_rx_rdy = 1'b1;
                k = 0;
                while (resp !== 8'hF0 && k < 20 * B) begin
                    @(negedge clk);
                    k++;
                end
                clr_rx_rdy = 1'b0;
            end
        join
        check_rx();
        pulse_clr();
        check_rx();

        // Bad stop bit
        send_rx(8'h3C, 1'b0, 2);
        check_rx();
        pulse_clr();

        // Randomised full-duplex traffic
        for (int it = 0; it < 10; it++) begin
            logic [15:0] c;
            logic [15:0] c2;
            logic [7:0]  rb;
            logic        stop_bit;
            logic        extra;
            int          rdly;
            int          pdly;
            c        = 16'($urandom);
            c2       = 16'($urandom);
            rb       = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            extra    = 1'($urandom);
            rdly     = $urandom_range(0, 100);
            pdly     = $urandom_range(5, 250);
            fork
                do_cmd(c, extra, c2, pdly);
                begin
                    repeat (rdly) @(negedge clk);
                    send_rx(rb, stop_bit, 2);
                end
            join
            repeat (4) @(negedge clk);
            check_tx();
            check_rx();
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                check_rx();
            end
        end

        // Asynchronous reset in the middle of a transfer
        if (!resp_rdy) send_rx(8'h5A, 1'b1, 2);
        cmd = 16'hFFFF;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b0;
        repeat (2 * B) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tx", TX, 1'b1);
        check("midrst_cmd_sent", cmd_sent, 1'b0);
        check("midrst_resp_rdy", resp_rdy, 1'b0);
        check("midrst_resp", resp, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
